// File: rtl/jcapture_pkg.sv
// Shared definitions for the triggered capture core: state encoding and the
// status width used by host-side decode.
package jcapture_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        WAIT = 3'd2,
        POST = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage

// File: rtl/jcapture_ram.sv
// Simple dual-port capture memory: one write port, one registered read port.
// Only the read register is reset; the array itself is left uninitialised.
module jcapture_ram #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 512,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[raddr];
        end
    end

    assign rdata = rd_data_q;

endmodule

// File: rtl/jcapture_trig.sv
// Triggered capture core: mask/value trigger (level or rising edge) with a
// pre-trigger window, capturing DEPTH samples into a ring buffer for readout.
module jcapture_trig
    import jcapture_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int DEPTH = 512,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   d,
    input  logic               sample_en,
    input  logic               arm,
    input  logic               abort,
    input  logic [WIDTH-1:0]   trig_mask,
    input  logic [WIDTH-1:0]   trig_val,
    input  logic               trig_edge,
    input  logic [AW-1:0]      pre_count,
    input  logic [AW-1:0]      rd_addr,
    output logic [WIDTH-1:0]   q,
    output logic [AW-1:0]      trig_pos,
    output logic [STATE_W-1:0] state,
    output logic               busy,
    output logic               update
);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] fill_q, fill_d;
    logic [AW-1:0] pre_c_q, pre_c_d;
    logic [AW-1:0] start_q, start_d;
    logic [AW-1:0] trig_pos_q, trig_pos_d;
    logic          match_prev_q, match_prev_d;
    logic          update_q, update_d;

    logic          match;
    logic          trig_hit;
    logic          we;

    assign match    = ((d ^ trig_val) & trig_mask) == '0;
    assign trig_hit = trig_edge ? (match & ~match_prev_q) : match;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        pre_c_d      = pre_c_q;
        start_d      = start_q;
        trig_pos_d   = trig_pos_q;
        match_prev_d = match_prev_q;
        update_d     = 1'b0;
        we           = 1'b0;

        if (sample_en) begin
            match_prev_d = match;
        end

        // abort outranks arm; arm outranks any sample taken in the same cycle
        if (abort) begin
            state_d = IDLE;
        end else if (arm) begin
            wr_ptr_d     = '0;
            fill_d       = '0;
            pre_c_d      = pre_count;
            match_prev_d = 1'b1;
            state_d      = (pre_count == '0) ? WAIT : PRE;
        end else if (sample_en) begin
            unique case (state_q)
                PRE: begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    fill_d   = fill_q + AW'(1);
                    if (fill_q + AW'(1) == pre_c_q) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (trig_hit) begin
                        start_d = wr_ptr_q - pre_c_q;
                        state_d = (pre_c_q == AW'(DEPTH - 1)) ? DONE : POST;
                    end
                end
                POST: begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (wr_ptr_q + AW'(1) == start_q) begin
                        state_d = DONE;
                    end
                end
                default: ;
            endcase
        end

        if (state_d == DONE && state_q != DONE) begin
            update_d   = 1'b1;
            trig_pos_d = pre_c_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            pre_c_q      <= '0;
            start_q      <= '0;
            trig_pos_q   <= '0;
            match_prev_q <= 1'b1;
            update_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            pre_c_q      <= pre_c_d;
            start_q      <= start_d;
            trig_pos_q   <= trig_pos_d;
            match_prev_q <= match_prev_d;
            update_q     <= update_d;
        end
    end

    jcapture_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (d),
        .raddr (start_q + rd_addr),
        .rdata (q)
    );

    assign trig_pos = trig_pos_q;
    assign state    = state_q;
    assign busy     = (state_q == PRE) || (state_q == WAIT) || (state_q == POST);
    assign update   = update_q;

endmodule

// File: tb/tb_jcapture_trig.sv
// Directed self-checking bench for jcapture_trig at WIDTH=32, DEPTH=16.
module tb_jcapture_trig;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] d;
    logic             sample_en;
    logic             arm;
    logic             abort;
    logic [WIDTH-1:0] trig_mask;
    logic [WIDTH-1:0] trig_val;
    logic             trig_edge;
    logic [AW-1:0]    pre_count;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] q;
    logic [AW-1:0]    trig_pos;
    logic [2:0]       state;
    logic             busy;
    logic             update;

    int checks   = 0;
    int failures = 0;
    int cnt      = 0;
    int upd_seen = 0;
    bit edge_pat = 1'b0;

    jcapture_trig #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .d         (d),
        .sample_en (sample_en),
        .arm       (arm),
        .abort     (abort),
        .trig_mask (trig_mask),
        .trig_val  (trig_val),
        .trig_edge (trig_edge),
        .pre_count (pre_count),
        .rd_addr   (rd_addr),
        .q         (q),
        .trig_pos  (trig_pos),
        .state     (state),
        .busy      (busy),
        .update    (update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Probe pattern: plain counter, or counter shifted up with a scripted bit 0
    // that is high for samples 0-5, low for 6-8 and high again from 9.
    function automatic logic [31:0] pat(input int c);
        logic [31:0] cv;
        logic        b;
        cv = c;
        b  = (c < 6) || (c >= 9);
        if (edge_pat) return {cv[30:0], b};
        return cv;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (update === 1'b1) upd_seen++;
    endtask

    task automatic arm_capture(input logic [AW-1:0] pre, input logic [31:0] mask,
                               input logic [31:0] val, input logic edg);
        pre_count = pre;
        trig_mask = mask;
        trig_val  = val;
        trig_edge = edg;
        sample_en = 1'b0;
        arm       = 1'b1;
        step();
        arm      = 1'b0;
        cnt      = 0;
        upd_seen = 0;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) begin
            sample_en = 1'b1;
            d         = pat(cnt);
            step();
            cnt++;
        end
        sample_en = 1'b0;
    endtask

    // Samples one cycle in every gap until DONE; returns the number of samples taken.
    task automatic run_until_done(input int gap, input string name, output int nsamp);
        int cyc;
        cyc = 0;
        while (state !== 3'd4 && cyc < 400) begin
            sample_en = (cyc % gap) == 0;
            d         = sample_en ? pat(cnt) : 32'hBAD0_0000;
            step();
            if (sample_en) cnt++;
            cyc++;
        end
        nsamp = cnt;
        checks++;
        if (state !== 3'd4) begin
            failures++;
            $display("[TB] FAIL %s_timeout state=%0d required=4", name, state);
        end
        // buffer must stay frozen while samples keep arriving in DONE
        for (int i = 0; i < 3; i++) begin
            sample_en = 1'b1;
            d         = 32'hDEAD_0000 + i;
            step();
        end
        sample_en = 1'b0;
    endtask

    task automatic read_check(input int addr, input logic [31:0] exp, input string name);
        rd_addr = addr[AW-1:0];
        step();
        checks++;
        if (q !== exp) begin
            failures++;
            $display("[TB] FAIL %s q[%0d]=%0d required=%0d", name, addr, q, exp);
        end
    endtask

    task automatic check_done(input string name, input int nsamp, input int exp_n,
                              input int exp_tp);
        checks++;
        if (nsamp != exp_n) begin
            failures++;
            $display("[TB] FAIL %s_samples got=%0d required=%0d", name, nsamp, exp_n);
        end
        checks++;
        if (trig_pos !== exp_tp[AW-1:0]) begin
            failures++;
            $display("[TB] FAIL %s_trig_pos got=%0d required=%0d", name, trig_pos, exp_tp);
        end
        checks++;
        if (upd_seen != 1) begin
            failures++;
            $display("[TB] FAIL %s_update pulses=%0d required=1", name, upd_seen);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        d         = '0;
        sample_en = 1'b0;
        arm       = 1'b0;
        abort     = 1'b0;
        trig_mask = '0;
        trig_val  = '0;
        trig_edge = 1'b0;
        pre_count = '0;
        rd_addr   = '0;
        step();
        step();
        reset = 1'b0;
        step();
        checks++;
        if (state !== 3'd0 || busy !== 1'b0 || update !== 1'b0 || q !== 32'd0 || trig_pos !== 4'd0) begin
            failures++;
            $display("[TB] FAIL reset state=%0d busy=%b update=%b q=%0h trig_pos=%0d required all 0",
                     state, busy, update, q, trig_pos);
        end
        run_n(10);
        checks++;
        if (state !== 3'd0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_hold state=%0d busy=%b required=0/0", state, busy);
        end
    endtask

    task automatic test_level(input int gap, input string name);
        int n;
        edge_pat = 1'b0;
        arm_capture(4'd4, 32'hFFFF_FFFF, 32'd20, 1'b0);
        run_until_done(gap, name, n);
        check_done(name, n, 32, 4);
        for (int i = 0; i < DEPTH; i++) read_check(i, 32'(16 + i), name);
    endtask

    task automatic test_edge();
        int n;
        edge_pat = 1'b1;
        arm_capture(4'd2, 32'h1, 32'h1, 1'b1);
        run_until_done(1, "edge", n);
        check_done("edge", n, 23, 2);
        read_check(0, 32'd14, "edge");
        read_check(2, 32'd19, "edge");
        read_check(15, 32'd45, "edge");
        edge_pat = 1'b0;
    endtask

    task automatic test_abort();
        int n;
        edge_pat = 1'b0;
        arm_capture(4'd4, 32'hFFFF_FFFF, 32'd20, 1'b0);
        run_n(23);
        checks++;
        if (state !== 3'd3 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_pre state=%0d busy=%b required=3/1", state, busy);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        run_n(3);
        checks++;
        if (state !== 3'd0 || busy !== 1'b0 || upd_seen != 0) begin
            failures++;
            $display("[TB] FAIL abort_post state=%0d busy=%b updates=%0d required=0/0/0",
                     state, busy, upd_seen);
        end
        arm   = 1'b1;
        abort = 1'b1;
        step();
        arm   = 1'b0;
        abort = 1'b0;
        run_n(5);
        checks++;
        if (state !== 3'd0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL arm_abort state=%0d busy=%b required=0/0", state, busy);
        end
        arm_capture(4'd4, 32'hFFFF_FFFF, 32'd20, 1'b0);
        run_until_done(1, "rearm", n);
        check_done("rearm", n, 32, 4);
        read_check(5, 32'd21, "rearm");
    endtask

    task automatic test_boundaries();
        int n;
        edge_pat = 1'b0;
        arm_capture(4'd0, 32'hFFFF_FFFF, 32'd0, 1'b0);
        checks++;
        if (state !== 3'd2) begin
            failures++;
            $display("[TB] FAIL pre0_arm state=%0d required=2", state);
        end
        run_until_done(1, "pre0", n);
        check_done("pre0", n, 16, 0);
        read_check(0, 32'd0, "pre0");
        read_check(15, 32'd15, "pre0");

        arm_capture(4'd15, 32'hFFFF_FFFF, 32'd20, 1'b0);
        run_until_done(1, "pre15", n);
        check_done("pre15", n, 21, 15);
        read_check(15, 32'd20, "pre15");
        read_check(0, 32'd5, "pre15");

        // samples 3 and 7 match inside PRE (7 is the last PRE sample); 11 is first eligible
        arm_capture(4'd8, 32'h3, 32'h3, 1'b0);
        run_until_done(1, "pre_ignore", n);
        check_done("pre_ignore", n, 19, 8);
        read_check(8, 32'd11, "pre_ignore");
        read_check(0, 32'd3, "pre_ignore");
    endtask

    initial begin
        test_reset();
        test_level(1, "level");
        test_edge();
        test_level(4, "gated");
        test_abort();
        test_boundaries();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jcapture_trig.md
Name: jcapture_trig

Overview:
Parameterised triggered capture core, the successor to the fixed 256-bit free-running capture. It samples a WIDTH-bit probe bundle into a DEPTH-entry ring buffer, qualified by a sample enable such as clk7_en. Capture is gated by a mask/value trigger in level or edge mode, with a programmable pre-trigger window. After capture completes the buffer is frozen for random-access readout by the JTAG/host side. Per-subsystem probe wrappers (fastram, chipram, ...) build the bundle and instantiate this block.

Parameters:
WIDTH, 256, probe bundle width in bits.
DEPTH, 512, samples per capture; must be a power of 2, at least 4.
AW, $clog2(DEPTH), address width (localparam, not overridable).

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
d  in  WIDTH  probe bundle.
sample_en  in  1  sample qualifier; nothing is written or evaluated when low.
arm  in  1  one-cycle pulse; starts a new capture.
abort  in  1  one-cycle pulse; cancels the capture and returns to IDLE.
trig_mask  in  WIDTH  bits participating in the trigger compare.
trig_val  in  WIDTH  compare value.
trig_edge  in  1  0 = level trigger, 1 = trigger on a rising match.
pre_count  in  AW  pre-trigger sample count, 0..DEPTH-1; latched on arm.
rd_addr  in  AW  readout index; 0 = oldest sample.
q  out  WIDTH  readout data; registered, 1-cycle latency.
trig_pos  out  AW  readout index of the trigger sample (= latched pre_count).
state  out  3  current state encoding.
busy  out  1  high in PRE, WAIT and POST.
update  out  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset: state = IDLE. q, trig_pos, update and busy are all 0. wr_ptr = 0. match_prev = 1.
- match = ((d ^ trig_val) & trig_mask) == 0. It is evaluated only on cycles with sample_en = 1.
- trig_hit = match in level mode. In edge mode, trig_hit = match & ~match_prev.
- match_prev updates on every sample_en cycle in every state. It is set to 1 on arm.
- States: IDLE, PRE, WAIT, POST, DONE.
- arm in any state: wr_ptr = 0, fill = 0, pre_c = pre_count latched. Next state = WAIT if pre_count == 0, else PRE.
- abort in any state → IDLE. abort wins over a simultaneous arm. No update pulse.
- PRE, each sample_en:
  - write d to mem[wr_ptr], increment wr_ptr, increment fill.
  - when fill+1 == pre_c → WAIT.
  - the trigger is ignored in PRE.
- WAIT, each sample_en:
  - write d to mem[wr_ptr], increment wr_ptr (wraps mod DEPTH).
  - on trig_hit: start = wr_ptr - pre_c (mod DEPTH).
  - then → DONE if pre_c == DEPTH-1, else → POST.
- POST, each sample_en:
  - write d to mem[wr_ptr], increment wr_ptr.
  - when wr_ptr+1 == start (mod DEPTH) → DONE, i.e. exactly DEPTH samples are held.
- DONE: no writes. The buffer is frozen until the next arm. Re-arm is allowed.
- update is high for exactly one clk on the transition into DONE.
- Readout: q <= mem[(start + rd_addr) mod DEPTH] every clk. Values are valid in DONE only; contents are undefined in other states.
- trig_pos <= pre_c on the transition into DONE.
- A trigger coinciding with the final PRE sample is not taken; WAIT begins on the next sample_en.
- sample_en low for any number of cycles stalls all progress without loss of state.
- Memory is an inferred simple dual-port RAM: 1 write port, 1 registered read port. No reset on the array.

Decomposition:
- jcapture_pkg: state enum typedef (IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4), and the STATE_W = 3 constant shared with host-side status decode.
- Sub-module jcapture_ram #(WIDTH, DEPTH): simple dual-port RAM with registered read. All control logic lives in jcapture_trig.

Test Plan:
Bench configuration: WIDTH=32, DEPTH=16. Unless stated otherwise, d = sample counter (0, 1, 2, … per sample_en).
- Reset: after reset, state=0, busy=0, update=0, q=0, trig_pos=0. Holding sample_en=1 without arm gives no state change.
- Level trigger: arm at sample 0, pre_count=4, mask=FFFFFFFF, val=20 → DONE after sample 31. rd_addr 0..15 returns 16..31. trig_pos=4. update pulses exactly once.
- Edge trigger: trig_edge=1, mask=1, val=1, d[0] held 1 from arm → no trigger. d[0] drops to 0, then rises to 1 at sample 9 → trigger on sample 9, not earlier.
- sample_en gating: repeat the level-trigger case with sample_en high one clk in four → identical buffer contents, trig_pos=4, same sample count.
- Abort and simultaneous events: abort mid-POST → IDLE, busy=0, no update. arm+abort in the same clk → IDLE. Re-arm then completes normally.
- Boundaries:
  - pre_count=0 with val=0: trigger on sample 0; q[rd_addr=0]=0, trig_pos=0.
  - pre_count=15: DONE on the trigger sample itself; q[15]=trigger value.
  - trigger value present during PRE is ignored.
